// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// The read port is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int IWIDTH     = 4,
    parameter int WWIDTH     = 8,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = 0
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              WrEn,
    input  logic [WWIDTH-1:0] DataIn,
    input  logic              RdEn,
    input  logic              Flush,
    output logic [WWIDTH-1:0] DataOut,
    output logic              DataValid,
    output logic [IWIDTH:0]   Count,
    output logic              IsFull,
    output logic              IsEmpty,
    output logic              AlmostFull,
    output logic              AlmostEmpty,
    output logic              Overflow,
    output logic              Underflow
);

    localparam logic [IWIDTH:0]   FULL_CNT = (IWIDTH+1)'(DEPTH);
    localparam logic [IWIDTH:0]   AF_CNT   = (IWIDTH+1)'(AFULL_LVL);
    localparam logic [IWIDTH:0]   AE_CNT   = (IWIDTH+1)'(AEMPTY_LVL);
    localparam logic [IWIDTH-1:0] LAST_PTR = IWIDTH'(DEPTH - 1);

    logic [WWIDTH-1:0] mem [DEPTH];
    logic [IWIDTH-1:0] wrPtr;
    logic [IWIDTH-1:0] rdPtr;
    logic              wrAccept;
    logic              rdAccept;

    function automatic logic [IWIDTH-1:0] nextPtr(input logic [IWIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + IWIDTH'(1);
    endfunction

    assign IsFull      = (Count == FULL_CNT);
    assign IsEmpty     = (Count == '0);
    assign AlmostFull  = (Count >= AF_CNT);
    assign AlmostEmpty = (Count <= AE_CNT);

    // Handshake: a request is taken in the cycle it is sampled only if the FIFO
    // can serve it (WrEn && !IsFull, RdEn && !IsEmpty) and Flush is low; a refused
    // request is dropped and flagged through Overflow/Underflow, never held pending.
    assign wrAccept = WrEn & ~IsFull & ~Flush;
    assign rdAccept = RdEn & ~IsEmpty & ~Flush;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (wrAccept) wrPtr <= nextPtr(wrPtr);
            if (rdAccept) rdPtr <= nextPtr(rdPtr);
            case ({wrAccept, rdAccept})
                2'b10:   Count <= Count + (IWIDTH+1)'(1);
                2'b01:   Count <= Count - (IWIDTH+1)'(1);
                default: Count <= Count;
            endcase
            if (WrEn && IsFull)  Overflow  <= 1'b1;
            if (RdEn && IsEmpty) Underflow <= 1'b1;
        end
    end

    // Storage is deliberately never cleared; Count gating keeps stale words hidden.
    always_ff @(posedge Clk) begin
        if (wrAccept) mem[wrPtr] <= DataIn;
    end

    if (FWFT != 0) begin : gFwft
        assign DataValid = ~IsEmpty;
        assign DataOut   = IsEmpty ? '0 : mem[rdPtr];
    end else begin : gRegRead
        always_ff @(posedge Clk or negedge ResetN) begin
            if (!ResetN) begin
                DataOut   <= '0;
                DataValid <= 1'b0;
            end else begin
                DataValid <= rdAccept;
                if (rdAccept) DataOut <= mem[rdPtr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a registered-read and a FWFT instance share one stimulus
// stream and are compared against a queue-based model of the FIFO.
module tb_sync_fifo;

    localparam int DEPTH = 4;
    localparam int IWIDTH = 2;
    localparam int WWIDTH = 8;
    localparam int AFL = 3;
    localparam int AEL = 1;
    localparam logic [8:0] RST_STAT = 9'b000_0_1_0_1_0_0;

    logic Clk = 1'b0;
    logic ResetN = 1'b1;
    logic WrEn = 1'b0;
    logic RdEn = 1'b0;
    logic Flush = 1'b0;
    logic [WWIDTH-1:0] DataIn = '0;

    logic [WWIDTH-1:0] DataOut0, DataOut1;
    logic DataValid0, DataValid1;
    logic [IWIDTH:0] Count0, Count1;
    logic IsFull0, IsEmpty0, AlmostFull0, AlmostEmpty0, Overflow0, Underflow0;
    logic IsFull1, IsEmpty1, AlmostFull1, AlmostEmpty1, Overflow1, Underflow1;
    logic [8:0] stat0, stat1;

    int checks = 0;
    int errors = 0;

    logic [WWIDTH-1:0] exp_q[$];
    logic mOvf = 1'b0;
    logic mUdf = 1'b0;
    logic [WWIDTH-1:0] mDout = '0;
    logic mValid = 1'b0;

    sync_fifo #(.DEPTH(DEPTH), .IWIDTH(IWIDTH), .WWIDTH(WWIDTH), .AFULL_LVL(AFL),
                .AEMPTY_LVL(AEL), .FWFT(0)) dutReg (
        .Clk(Clk), .ResetN(ResetN), .WrEn(WrEn), .DataIn(DataIn), .RdEn(RdEn), .Flush(Flush),
        .DataOut(DataOut0), .DataValid(DataValid0), .Count(Count0), .IsFull(IsFull0),
        .IsEmpty(IsEmpty0), .AlmostFull(AlmostFull0), .AlmostEmpty(AlmostEmpty0),
        .Overflow(Overflow0), .Underflow(Underflow0)
    );

    sync_fifo #(.DEPTH(DEPTH), .IWIDTH(IWIDTH), .WWIDTH(WWIDTH), .AFULL_LVL(AFL),
                .AEMPTY_LVL(AEL), .FWFT(1)) dutFwft (
        .Clk(Clk), .ResetN(ResetN), .WrEn(WrEn), .DataIn(DataIn), .RdEn(RdEn), .Flush(Flush),
        .DataOut(DataOut1), .DataValid(DataValid1), .Count(Count1), .IsFull(IsFull1),
        .IsEmpty(IsEmpty1), .AlmostFull(AlmostFull1), .AlmostEmpty(AlmostEmpty1),
        .Overflow(Overflow1), .Underflow(Underflow1)
    );

    assign stat0 = {Count0, IsFull0, IsEmpty0, AlmostFull0, AlmostEmpty0, Overflow0, Underflow0};
    assign stat1 = {Count1, IsFull1, IsEmpty1, AlmostFull1, AlmostEmpty1, Overflow1, Underflow1};

    always #5 Clk = ~Clk;

    function automatic logic [8:0] exp_status();
        int n = exp_q.size();
        return {3'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL, mOvf, mUdf};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mOvf = 1'b0;
        mUdf = 1'b0;
        mDout = '0;
        mValid = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [WWIDTH-1:0] din,
                              input logic rd, input logic fl);
        int n = exp_q.size();
        if (fl) begin
            exp_q.delete();
            mOvf = 1'b0;
            mUdf = 1'b0;
            mValid = 1'b0;
        end else begin
            if (wr && n == DEPTH) mOvf = 1'b1;
            if (rd && n == 0) mUdf = 1'b1;
            mValid = 1'b0;
            if (rd && n > 0) begin
                mDout = exp_q.pop_front();
                mValid = 1'b1;
            end
            if (wr && n < DEPTH) exp_q.push_back(din);
        end
    endtask

    // Drive one cycle of requests, advance the model on the same edge, settle 1ns.
    task automatic step(input logic wr, input logic [WWIDTH-1:0] din,
                        input logic rd, input logic fl);
        WrEn = wr;
        DataIn = din;
        RdEn = rd;
        Flush = fl;
        @(posedge Clk);
        model_step(wr, din, rd, fl);
        #1;
        WrEn = 1'b0;
        RdEn = 1'b0;
        Flush = 1'b0;
    endtask

    task automatic test_reset();
        #1 ResetN = 1'b0;
        #2;
        checks++;
        if (stat0 !== RST_STAT) begin errors++; $display("FAIL reset_stat_reg got %b want %b", stat0, RST_STAT); end
        checks++;
        if (stat1 !== RST_STAT) begin errors++; $display("FAIL reset_stat_fwft got %b want %b", stat1, RST_STAT); end
        checks++;
        if (DataOut0 !== 8'h00 || DataValid0 !== 1'b0) begin
            errors++; $display("FAIL reset_out_reg got %h/%b want 00/0", DataOut0, DataValid0);
        end
        checks++;
        if (DataOut1 !== 8'h00 || DataValid1 !== 1'b0) begin
            errors++; $display("FAIL reset_out_fwft got %h/%b want 00/0", DataOut1, DataValid1);
        end
        model_reset();
        @(negedge Clk);
        ResetN = 1'b1;
    endtask

    task automatic test_basic();
        logic [WWIDTH-1:0] e;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(17 * (i + 1)), 1'b0, 1'b0);
        checks++;
        if (Count0 !== 3'd4 || IsFull0 !== 1'b1) begin
            errors++; $display("FAIL basic_full got count %0d full %b want 4 1", Count0, IsFull0);
        end
        checks++;
        if (DataOut1 !== 8'h11 || DataValid1 !== 1'b1) begin
            errors++; $display("FAIL basic_fwft_head got %h/%b want 11/1", DataOut1, DataValid1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            e = 8'(17 * (i + 1));
            checks++;
            if (DataOut0 !== e || DataValid0 !== 1'b1) begin
                errors++; $display("FAIL basic_read%0d got %h/%b want %h/1", i, DataOut0, DataValid0, e);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (DataValid0 !== 1'b0 || DataOut0 !== 8'h44) begin
            errors++; $display("FAIL basic_hold got %h/%b want 44/0", DataOut0, DataValid0);
        end
        checks++;
        if (Count0 !== 3'd0 || IsEmpty0 !== 1'b1) begin
            errors++; $display("FAIL basic_empty got count %0d empty %b want 0 1", Count0, IsEmpty0);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(17 * (i + 1)), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        checks++;
        if (Overflow0 !== 1'b1 || Count0 !== 3'd4) begin
            errors++; $display("FAIL ovf_set got ovf %b count %0d want 1 4", Overflow0, Count0);
        end
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (Count0 !== 3'd3 || Overflow0 !== 1'b1) begin
            errors++; $display("FAIL ovf_rdwr got count %0d ovf %b want 3 1", Count0, Overflow0);
        end
        checks++;
        if (DataOut0 !== 8'h11 || DataValid0 !== 1'b1) begin
            errors++; $display("FAIL ovf_head got %h/%b want 11/1", DataOut0, DataValid0);
        end
        checks++;
        if (DataOut1 !== 8'h22 || Overflow1 !== 1'b1) begin
            errors++; $display("FAIL ovf_fwft got %h/%b want 22/1", DataOut1, Overflow1);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 8'h99, 1'b0, 1'b1);
        checks++;
        if (Count0 !== 3'd0 || Overflow0 !== 1'b0 || IsEmpty0 !== 1'b1) begin
            errors++; $display("FAIL flush_clear got count %0d ovf %b empty %b want 0 0 1", Count0, Overflow0, IsEmpty0);
        end
        checks++;
        if (DataValid0 !== 1'b0 || DataOut0 !== 8'h11) begin
            errors++; $display("FAIL flush_dout got %h/%b want 11/0", DataOut0, DataValid0);
        end
        checks++;
        if (DataValid1 !== 1'b0 || Count1 !== 3'd0) begin
            errors++; $display("FAIL flush_fwft got valid %b count %0d want 0 0", DataValid1, Count1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (Count0 !== 3'd0) begin errors++; $display("FAIL flush_write_ignored got %0d want 0", Count0); end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (Underflow0 !== 1'b1 || DataValid0 !== 1'b0) begin
            errors++; $display("FAIL udf_set got udf %b valid %b want 1 0", Underflow0, DataValid0);
        end
        step(1'b1, 8'h66, 1'b1, 1'b0);
        checks++;
        if (Count0 !== 3'd1 || DataValid0 !== 1'b0 || Underflow0 !== 1'b1) begin
            errors++; $display("FAIL udf_rdwr got count %0d valid %b udf %b want 1 0 1", Count0, DataValid0, Underflow0);
        end
        checks++;
        if (DataOut1 !== 8'h66 || DataValid1 !== 1'b1) begin
            errors++; $display("FAIL udf_fwft got %h/%b want 66/1", DataOut1, DataValid1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [WWIDTH-1:0] e;
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i + 3), 1'b1, 1'b0);
            e = 8'(i + 1);
            checks++;
            if (DataOut0 !== e || DataValid0 !== 1'b1 || stat0 !== 9'b010_0_0_0_0_0_0) begin
                errors++; $display("FAIL wrap%0d got %h/%b stat %b want %h/1 stat 010000000", i, DataOut0, DataValid0, stat0, e);
            end
            e = 8'(i + 2);
            checks++;
            if (DataOut1 !== e || stat1 !== 9'b010_0_0_0_0_0_0) begin
                errors++; $display("FAIL wrap_fwft%0d got %h stat %b want %h stat 010000000", i, DataOut1, stat1, e);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_fwft();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (DataOut1 !== 8'hA5 || DataValid1 !== 1'b1 || DataValid0 !== 1'b0) begin
            errors++; $display("FAIL fwft_show got %h/%b reg valid %b want a5/1 0", DataOut1, DataValid1, DataValid0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (IsEmpty1 !== 1'b1 || DataValid1 !== 1'b0) begin
            errors++; $display("FAIL fwft_pop got empty %b valid %b want 1 0", IsEmpty1, DataValid1);
        end
        checks++;
        if (DataOut0 !== 8'hA5 || DataValid0 !== 1'b1) begin
            errors++; $display("FAIL fwft_regpath got %h/%b want a5/1", DataOut0, DataValid0);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b1, 1'b0);
        WrEn = 1'b1;
        DataIn = 8'h30;
        @(negedge Clk);
        #1 ResetN = 1'b0;
        #1;
        checks++;
        if (stat0 !== RST_STAT || stat1 !== RST_STAT) begin
            errors++; $display("FAIL midreset_stat got %b/%b want %b", stat0, stat1, RST_STAT);
        end
        checks++;
        if (DataOut0 !== 8'h00 || DataValid0 !== 1'b0 || DataValid1 !== 1'b0 || DataOut1 !== 8'h00) begin
            errors++; $display("FAIL midreset_out got %h/%b %h/%b want 00/0 00/0", DataOut0, DataValid0, DataOut1, DataValid1);
        end
        model_reset();
        WrEn = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        checks++;
        if (Count0 !== 3'd1 || DataOut1 !== 8'h77) begin
            errors++; $display("FAIL midreset_first got count %0d fwft %h want 1 77", Count0, DataOut1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic wr, rd, fl;
        logic [8:0] es;
        for (int c = 0; c < 400; c++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 24) == 0);
            step(wr, 8'($urandom_range(0, 255)), rd, fl);
            es = exp_status();
            checks++;
            if (stat0 !== es || stat1 !== es) begin
                errors++; $display("FAIL rand_stat c%0d got %b/%b want %b", c, stat0, stat1, es);
            end
            checks++;
            if (DataOut0 !== mDout || DataValid0 !== mValid) begin
                errors++; $display("FAIL rand_reg c%0d got %h/%b want %h/%b", c, DataOut0, DataValid0, mDout, mValid);
            end
            checks++;
            if (DataValid1 !== (exp_q.size() > 0) || (exp_q.size() > 0 && DataOut1 !== exp_q[0])) begin
                errors++; $display("FAIL rand_fwft c%0d got %h/%b want size %0d", c, DataOut1, DataValid1, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flush();
        test_underflow();
        test_wrap();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of storage words, SHALL be >= 2; any integer allowed, not only powers of two.
REQ-002 Parameter IWIDTH, default 4: pointer width, SHALL equal ceil(log2(DEPTH)).
REQ-003 Parameter WWIDTH, default 8: data word width.
REQ-004 Parameter AFULL_LVL, default 12: AlmostFull threshold, range 1..DEPTH.
REQ-005 Parameter AEMPTY_LVL, default 4: AlmostEmpty threshold, range 0..DEPTH-1.
REQ-006 Parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-007 Clk  in  1  single clock; all logic on rising edge.
REQ-008 ResetN  in  1  asynchronous, active-low reset.
REQ-009 WrEn  in  1  write request.
REQ-010 DataIn  in  WWIDTH  write data.
REQ-011 RdEn  in  1  read request.
REQ-012 Flush  in  1  synchronous clear.
REQ-013 DataOut  out  WWIDTH  read data.
REQ-014 DataValid  out  1  DataOut holds a valid word.
REQ-015 Count  out  IWIDTH+1  words stored, 0..DEPTH.
REQ-016 IsFull, IsEmpty, AlmostFull, AlmostEmpty  out  1 each  status flags.
REQ-017 Overflow, Underflow  out  1 each  sticky error flags.

Function
REQ-018 Write accepted iff WrEn=1, IsFull=0, Flush=0; word stored at write pointer, which advances.
REQ-019 Read accepted iff RdEn=1, IsEmpty=0, Flush=0; read pointer advances.
REQ-020 Both pointers SHALL wrap DEPTH-1 -> 0.
REQ-021 Count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-022 When full with WrEn=RdEn=1: read accepted, write rejected, Overflow set.
REQ-023 When empty with WrEn=RdEn=1: write accepted, read rejected, Underflow set.
REQ-024 Any rejected WrEn (full) SHALL set Overflow; any rejected RdEn (empty) SHALL set Underflow; both remain set until Flush or reset.
REQ-025 Flags decode from registered Count: IsFull = (Count==DEPTH); IsEmpty = (Count==0); AlmostFull = (Count>=AFULL_LVL); AlmostEmpty = (Count<=AEMPTY_LVL).
REQ-026 All flags SHALL update on the same edge as Count, i.e. visible the cycle after the accepted operation.
REQ-027 FWFT=0: on an accepted read, DataOut <= head word and DataValid=1 for exactly the next cycle; DataOut holds its value otherwise; latency 1 cycle.
REQ-028 FWFT=1: DataOut SHALL present the head word whenever IsEmpty=0; DataValid = !IsEmpty; RdEn acknowledges and pops the head; a word written into an empty FIFO appears on DataOut the cycle after the write.
REQ-029 Flush has priority over WrEn/RdEn: pointers and Count -> 0, Overflow/Underflow -> 0, DataValid -> 0; DataOut retains its value in FWFT=0.
REQ-030 Storage array SHALL NOT be reset or cleared; stale contents SHALL never reach DataOut with DataValid=1.

Reset
REQ-031 ResetN=0 SHALL immediately force: pointers 0, Count 0, IsEmpty 1, IsFull 0, AlmostEmpty 1, AlmostFull 0, Overflow 0, Underflow 0, DataValid 0, DataOut 0.
REQ-032 Reset asserted mid-operation SHALL abort all in-flight reads/writes; first operation is accepted on the first rising edge after ResetN deasserts.

Verification (DEPTH=4, WWIDTH=8, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-033 FWFT=0: write 0x11,0x22,0x33,0x44, then 4 reads -> Count 4, IsFull=1 after last write; DataOut 0x11..0x44 each one cycle after RdEn with DataValid=1; final Count 0, IsEmpty=1.
REQ-034 Full FIFO, WrEn=1 with 0x55 -> write rejected, Overflow=1, Count stays 4; then WrEn=RdEn=1 -> read of head accepted, Count 3, Overflow still 1.
REQ-035 Empty FIFO, RdEn=1 -> Underflow=1, DataValid stays 0; then WrEn=RdEn=1 with 0x66 -> Count 1, DataValid 0.
REQ-036 Wrap: 10 cycles of write+read after pre-filling 2 words, incrementing data -> Count constant 2, output sequence in order, no flag changes.
REQ-037 FWFT=1: write 0xA5 into empty -> next cycle DataOut=0xA5, DataValid=1 without RdEn; RdEn -> IsEmpty=1, DataValid=0.
REQ-038 Count 3 with Overflow=1, Flush=1 together with WrEn=1 -> Count 0, Overflow 0, write ignored; ResetN pulse low mid-write -> all REQ-031 values immediately.
